// File: rtl/trap_pkg.sv
// Shared types for the trapezoid peak detector: sample width, FSM states, the
// event record carried through the output slot, and a saturating increment.
package trap_pkg;

  localparam int SAMPLE_W = 14;
  localparam int CNT_W    = 16;
  localparam int TS_W_MAX = 32;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    HOLDOFF
  } state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] amp;
    logic [TS_W_MAX-1:0] ts;
    logic [CNT_W-1:0]    width;
    logic                pileup;
  } evt_rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/event_slot.sv
// Single-entry valid/ready output register. A load that arrives while the slot is
// full and not being drained is discarded and flagged on the combinational drop pulse.
module event_slot
  import trap_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  evt_rec_t load_rec,
  input  logic     ready,
  output logic     valid,
  output evt_rec_t rec,
  output logic     drop
);

  logic can_load;

  // A full slot may still take a new record on the edge its current one is accepted.
  assign can_load = ~valid | ready;
  assign drop     = load & ~can_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      rec   <= '0;
    end else if (load && can_load) begin
      valid <= 1'b1;
      rec   <= load_rec;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/trapezoid_peak_detector.sv
// Arms on threshold crossings of the filtered sample stream, tracks peak/timestamp/width
// and emits one record per pulse. Optional pile-up cut-off: define TRAP_PEAK_PILEUP_EN.
module trapezoid_peak_detector
  import trap_pkg::*;
#(
  parameter int HYST      = 16,
  parameter int TS_W      = 32,
  parameter int MAX_WIDTH = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] threshold,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [SAMPLE_W-1:0] evt_amp,
  output logic [TS_W-1:0]     evt_ts,
  output logic [CNT_W-1:0]    evt_width,
  output logic                evt_pileup,
  output logic [CNT_W-1:0]    drop_cnt
);

  localparam logic signed [SAMPLE_W:0] HYST_EXT = (SAMPLE_W+1)'(HYST);
`ifdef TRAP_PEAK_PILEUP_EN
  localparam logic [CNT_W-1:0] PILE_W = CNT_W'(MAX_WIDTH);
`endif

  state_e                     state;
  logic [TS_W-1:0]            ts;
  logic signed [SAMPLE_W-1:0] peak;
  logic [TS_W-1:0]            peak_ts;
  logic [CNT_W-1:0]           width;

  logic signed [SAMPLE_W:0]   s_ext;
  logic signed [SAMPLE_W:0]   thr_lo;
  logic                       at_thr;
  logic                       above_lo;
  logic signed [SAMPLE_W-1:0] peak_nxt;
  logic [TS_W-1:0]            peak_ts_nxt;
  logic [CNT_W-1:0]           width_inc;
  logic                       emit;
  logic                       pileup_hit;
  evt_rec_t                   rec;
  evt_rec_t                   slot_rec;
  logic                       drop;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    s_ext       = {sample[SAMPLE_W-1], sample};
    // Widened by one bit so threshold - HYST never wraps for negative thresholds.
    thr_lo      = $signed({threshold[SAMPLE_W-1], threshold}) - HYST_EXT;
    at_thr      = $signed(sample) >= $signed(threshold);
    above_lo    = s_ext >= thr_lo;
    peak_nxt    = peak;
    peak_ts_nxt = peak_ts;
    width_inc   = sat_inc(width);
    emit        = 1'b0;
    pileup_hit  = 1'b0;

    if (sample_valid && state == ARMED) begin
      if ($signed(sample) > peak) begin
        peak_nxt    = $signed(sample);
        peak_ts_nxt = ts;
      end
      if (!above_lo) begin
        emit = 1'b1;
`ifdef TRAP_PEAK_PILEUP_EN
      end else if (width_inc == PILE_W) begin
        emit       = 1'b1;
        pileup_hit = 1'b1;
`endif
      end
    end

    rec.amp    = peak_nxt;
    rec.ts     = TS_W_MAX'(peak_ts_nxt);
    rec.width  = pileup_hit ? width_inc : width;
    rec.pileup = pileup_hit;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ts       <= '0;
      peak     <= '0;
      peak_ts  <= '0;
      width    <= '0;
      drop_cnt <= '0;
    end else begin
      ts <= ts + TS_W'(1);
      if (drop) drop_cnt <= sat_inc(drop_cnt);

      if (sample_valid) begin
        case (state)
          IDLE: begin
            if (at_thr) begin
              state   <= ARMED;
              peak    <= $signed(sample);
              peak_ts <= ts;
              width   <= CNT_W'(1);
            end
          end
          ARMED: begin
            peak    <= peak_nxt;
            peak_ts <= peak_ts_nxt;
            if (!emit) width <= width_inc;
`ifdef TRAP_PEAK_PILEUP_EN
            if (emit) state <= pileup_hit ? HOLDOFF : IDLE;
          end
          HOLDOFF: begin
            if (!above_lo) state <= IDLE;
`else
            if (emit) state <= IDLE;
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  event_slot u_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (emit),
    .load_rec (rec),
    .ready    (evt_ready),
    .valid    (evt_valid),
    .rec      (slot_rec),
    .drop     (drop)
  );

  assign evt_amp    = slot_rec.amp;
  assign evt_ts     = slot_rec.ts[TS_W-1:0];
  assign evt_width  = slot_rec.width;
  assign evt_pileup = slot_rec.pileup;

endmodule

// File: tb/tb_trapezoid_peak_detector.sv
// Directed and randomized pulses against a whole-pulse reference model (arm index,
// end index, maximum and first-maximum timestamp computed over the logged sequence).
module tb_trapezoid_peak_detector;
  import trap_pkg::*;

  localparam int HYST = 16;
`ifdef TRAP_PEAK_PILEUP_EN
  localparam int MAXW = 8;
`else
  localparam int MAXW = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic [13:0] threshold = '0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [13:0] evt_amp;
  logic [31:0] evt_ts;
  logic [15:0] evt_width;
  logic        evt_pileup;
  logic [15:0] drop_cnt;

  int          n_cmp = 0;
  int          n_fail = 0;
  int unsigned cyc;
  int          sq[$];
  int unsigned tq[$];

  trapezoid_peak_detector #(.HYST(HYST), .TS_W(32), .MAX_WIDTH(MAXW)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample),
    .sample_valid (sample_valid),
    .threshold    (threshold),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_amp      (evt_amp),
    .evt_ts       (evt_ts),
    .evt_width    (evt_width),
    .evt_pileup   (evt_pileup),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  // Bench-side timebase: the value ts will hold at the next rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input int s, input int gap);
    sample = 14'(s);
    sample_valid = 1'b1;
    sq.push_back(s);
    tq.push_back(cyc);
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic consume(input string tag);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    check(tag, 64'(evt_valid), 64'd0);
  endtask

  task automatic check_rec(input string tag, input logic [13:0] amp, input logic [31:0] ets,
                           input logic [15:0] w, input logic pile);
    check({tag, ".valid"}, 64'(evt_valid), 64'd1);
    check({tag, ".amp"}, 64'(evt_amp), 64'(amp));
    check({tag, ".ts"}, 64'(evt_ts), 64'(ets));
    check({tag, ".width"}, 64'(evt_width), 64'(w));
    check({tag, ".pileup"}, 64'(evt_pileup), 64'(pile));
  endtask

  // Whole-pulse reference: arm at the first sample >= thr, end at the first later sample
  // below thr - HYST; width is the span between them, amp the maximum inside it.
  function automatic void model(input int thr, output logic [13:0] amp,
                                output logic [31:0] ets, output logic [15:0] w);
    int a = -1;
    int e;
    int pk;
    for (int i = 0; i < sq.size(); i++)
      if (a < 0 && sq[i] >= thr) a = i;
    e = sq.size();
    for (int i = a + 1; i < sq.size(); i++)
      if (sq[i] < thr - HYST) begin
        e = i;
        break;
      end
    pk = sq[a];
    ets = tq[a];
    for (int i = a; i < e; i++)
      if (sq[i] > pk) begin
        pk = sq[i];
        ets = tq[i];
      end
    amp = 14'(pk);
    w = 16'(e - a);
  endfunction

  logic [13:0] m_amp;
  logic [31:0] m_ts;
  logic [15:0] m_w;
  logic [31:0] saved_ts;
  int          thr;
  int          gap;
  int          k;

  initial begin
    // Reset state
    do_reset();
    check("rst.valid", 64'(evt_valid), 64'd0);
    check("rst.amp", 64'(evt_amp), 64'd0);
    check("rst.ts", 64'(evt_ts), 64'd0);
    check("rst.width", 64'(evt_width), 64'd0);
    check("rst.pileup", 64'(evt_pileup), 64'd0);
    check("rst.drop", 64'(drop_cnt), 64'd0);

    // Basic pulse, ts = 0 at the first sample
    threshold = 14'd100;
    sq.delete(); tq.delete();
    send(0, 0); send(50, 0); send(120, 0); send(300, 0); send(300, 0); send(150, 0);
    check("p1.early", 64'(evt_valid), 64'd0);
    send(80, 0);
    check_rec("p1", 14'd300, 32'd3, 16'd4, 1'b0);
    send(0, 0);
    check("p1.hold", 64'(evt_valid), 64'd1);
    consume("p1.fall");

    // Same pulse with three idle cycles between samples
    sq.delete(); tq.delete();
    send(0, 3); send(50, 3); send(120, 3); send(300, 3); send(300, 3); send(150, 3);
    send(80, 0);
    model(100, m_amp, m_ts, m_w);
    check_rec("p2", 14'd300, m_ts, 16'd4, 1'b0);
    consume("p2.fall");

    // Randomized pulses with random gaps and repeated plateau values
    for (int p = 0; p < 12; p++) begin
      thr = int'($urandom_range(50, 2000));
      threshold = 14'(thr);
      gap = int'($urandom_range(0, 3));
      sq.delete(); tq.delete();
      k = int'($urandom_range(0, 2));
      for (int i = 0; i < k; i++) send(thr - 1 - int'($urandom_range(0, 400)), gap);
      send(thr + int'($urandom_range(0, 30)), gap);
      k = int'($urandom_range(0, 6));
      for (int i = 0; i < k; i++) send(thr - HYST + int'($urandom_range(0, HYST + 30)), gap);
      send(thr - HYST - 1 - int'($urandom_range(0, 200)), 0);
      model(thr, m_amp, m_ts, m_w);
      check_rec("rnd", m_amp, m_ts, m_w, 1'b0);
      consume("rnd.fall");
    end
    check("rnd.drop", 64'(drop_cnt), 64'd0);

    // Slot full with evt_ready low: two later records dropped, first held
    threshold = 14'd100;
    sq.delete(); tq.delete();
    send(200, 0);
    saved_ts = tq[0];
    send(0, 0);
    send(210, 0); send(0, 0);
    send(220, 0); send(0, 0);
    check_rec("full", 14'd200, saved_ts, 16'd1, 1'b0);
    check("full.drop", 64'(drop_cnt), 64'd2);
    consume("full.fall");

    // New record completes on the same edge as the handshake
    sq.delete(); tq.delete();
    send(180, 0); send(0, 0);
    check("same.first", 64'(evt_amp), 64'd180);
    sq.delete(); tq.delete();
    send(250, 0);
    evt_ready = 1'b1;
    send(0, 0);
    evt_ready = 1'b0;
    check_rec("same", 14'd250, tq[0], 16'd1, 1'b0);
    check("same.drop", 64'(drop_cnt), 64'd2);
    consume("same.fall");

    // Reset in the middle of an armed pulse discards it
    sq.delete(); tq.delete();
    send(200, 0); send(500, 0);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid.valid", 64'(evt_valid), 64'd0);
    check("mid.amp", 64'(evt_amp), 64'd0);
    check("mid.ts", 64'(evt_ts), 64'd0);
    check("mid.width", 64'(evt_width), 64'd0);
    check("mid.drop", 64'(drop_cnt), 64'd0);
    send(0, 0); send(90, 0); send(0, 0);
    check("mid.idle", 64'(evt_valid), 64'd0);

`ifdef TRAP_PEAK_PILEUP_EN
    // Pile-up: emit at MAX_WIDTH, then hold off without a second record
    sq.delete(); tq.delete();
    for (int i = 0; i < 8; i++) send(400, 0);
    check_rec("pile", 14'd400, tq[0], 16'd8, 1'b1);
    evt_ready = 1'b1;
    for (int i = 0; i < 12; i++) send(400, 0);
    send(0, 0);
    check("pile.none", 64'(evt_valid), 64'd0);
    evt_ready = 1'b0;
    check("pile.drop", 64'(drop_cnt), 64'd0);
    sq.delete(); tq.delete();
    send(100, 0); send(0, 0);
    check_rec("pile.rearm", 14'd100, tq[0], 16'd1, 1'b0);
    consume("pile.fall");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
